// File: rtl/t01_keypad_pkg.sv
// Shared types and constants for the keypad entry controller.
//   state_e   : controller state (COLLECT gathers keys, SEND streams the entry)
//   KEY_*     : ASCII codes with special meaning to the edit rules
package t01_keypad_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        SEND    = 1'b1
    } state_e;

    localparam logic [7:0] KEY_ENTER = 8'h23;  // '#'
    localparam logic [7:0] KEY_BKSP  = 8'h2A;  // '*'
    localparam logic [7:0] KEY_NONE  = 8'h00;  // unrecognised scan code

endpackage

// File: rtl/t01_keypad_entry_ctrl_if.sv
// Byte stream from the entry controller to the downstream consumer.
//   out_valid : byte available
//   out_data  : entry byte, first-typed first
//   out_last  : final byte of the entry
//   out_ready : consumer accepts the byte
// master = controller side, slave = consumer side.
interface t01_keypad_entry_ctrl_if;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/t01_scan_divider.sv
// Free-running divider pacing the keypad scanner's column advance.
//   clk   : system clock
//   nRST  : asynchronous active-low reset
//   pulse : one-cycle pulse every DIV cycles, high while the count is DIV-1
module t01_scan_divider #(
    parameter int DIV = 1000
) (
    input  logic clk,
    input  logic nRST,
    output logic pulse
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          pulse_r;

    // Count 0..DIV-1 and register the pulse so it lines up with count == DIV-1.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt_r   <= '0;
            pulse_r <= 1'b0;
        end else begin
            if (cnt_r == CW'(DIV - 1)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            pulse_r <= (cnt_r == CW'(DIV - 2));
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/t01_keypad_entry_ctrl.sv
// Keypad entry controller: paces the scanner, assembles keypresses into an
// entry with backspace ('*') and enter ('#'), discards idle entries, and
// streams a committed entry byte by byte to the consumer.
//   clk, nRST  : clock, asynchronous active-low reset
//   scan_en    : one-cycle scanner column-advance pulse
//   key_valid  : keypress strobe, key_data = ASCII (0 = unrecognised)
//   clear      : synchronous abort of the current entry (any state)
//   out_if     : valid/ready byte stream with last flag (master side)
//   busy       : high while streaming
//   entry_len  : registered character count
//   overflow   : pulse, key rejected because the buffer is full
//   dropped    : pulse, key arrived while streaming or together with clear
//   timed_out  : pulse, entry discarded after TIMEOUT idle cycles
module t01_keypad_entry_ctrl
    import t01_keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int MAX_LEN  = 8,
    parameter int TIMEOUT  = 5000000
) (
    input  logic                           clk,
    input  logic                           nRST,
    output logic                           scan_en,
    input  logic                           key_valid,
    input  logic [7:0]                     key_data,
    input  logic                           clear,
    t01_keypad_entry_ctrl_if.master        out_if,
    output logic                           busy,
    output logic [$clog2(MAX_LEN+1)-1:0]   entry_len,
    output logic                           overflow,
    output logic                           dropped,
    output logic                           timed_out
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int PW = $clog2(MAX_LEN);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] PTR_ZERO = '0;

    state_e        state_r;
    logic [LW-1:0] len_r;
    logic [PW-1:0] rd_ptr_r;
    logic [TW-1:0] idle_r;
    logic [7:0]    buf_r [MAX_LEN];
    logic          out_valid_r;
    logic [7:0]    out_data_r;
    logic          out_last_r;
    logic          busy_r;
    logic          overflow_r;
    logic          dropped_r;
    logic          timed_out_r;

    logic [PW-1:0] rd_nxt_s;
    logic          nxt_is_last_s;

    t01_scan_divider #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .nRST  (nRST),
        .pulse (scan_en)
    );

    // Stream bytes are registered, so precompute the byte following the current one.
    assign rd_nxt_s      = rd_ptr_r + PW'(1);
    assign nxt_is_last_s = ((LW+1)'(rd_ptr_r) + (LW+1)'(2)) == (LW+1)'(len_r);

    // Controller FSM: edit rules, idle timer and stream handshake, all outputs registered.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_r     <= COLLECT;
            len_r       <= '0;
            rd_ptr_r    <= '0;
            idle_r      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= 8'h00;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            overflow_r  <= 1'b0;
            dropped_r   <= 1'b0;
            timed_out_r <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else begin
            overflow_r  <= 1'b0;
            dropped_r   <= 1'b0;
            timed_out_r <= 1'b0;
            if (clear) begin
                // Abort wins over everything, including a coincident key.
                state_r     <= COLLECT;
                len_r       <= '0;
                rd_ptr_r    <= '0;
                idle_r      <= '0;
                out_valid_r <= 1'b0;
                out_data_r  <= 8'h00;
                out_last_r  <= 1'b0;
                busy_r      <= 1'b0;
                dropped_r   <= key_valid;
            end else begin
                case (state_r)
                    COLLECT: begin
                        if (key_valid) begin
                            // Any key restarts the idle timer, even on the timeout cycle.
                            idle_r <= '0;
                            if (key_data == KEY_BKSP) begin
                                if (len_r != '0) begin
                                    len_r <= len_r - LW'(1);
                                end
                            end else if (key_data == KEY_ENTER) begin
                                if (len_r != '0) begin
                                    state_r     <= SEND;
                                    rd_ptr_r    <= '0;
                                    out_valid_r <= 1'b1;
                                    busy_r      <= 1'b1;
                                    out_data_r  <= buf_r[PTR_ZERO];
                                    out_last_r  <= (len_r == LW'(1));
                                end
                            end else if (key_data != KEY_NONE) begin
                                if (len_r < LW'(MAX_LEN)) begin
                                    buf_r[len_r[PW-1:0]] <= key_data;
                                    len_r                <= len_r + LW'(1);
                                end else begin
                                    overflow_r <= 1'b1;
                                end
                            end
                        end else if (len_r == '0) begin
                            idle_r <= '0;
                        end else if (idle_r == TW'(TIMEOUT - 1)) begin
                            len_r       <= '0;
                            idle_r      <= '0;
                            timed_out_r <= 1'b1;
                        end else begin
                            idle_r <= idle_r + TW'(1);
                        end
                    end
                    SEND: begin
                        idle_r    <= '0;
                        dropped_r <= key_valid;
                        if (out_if.out_ready) begin
                            if (out_last_r) begin
                                state_r     <= COLLECT;
                                len_r       <= '0;
                                rd_ptr_r    <= '0;
                                out_valid_r <= 1'b0;
                                out_data_r  <= 8'h00;
                                out_last_r  <= 1'b0;
                                busy_r      <= 1'b0;
                            end else begin
                                rd_ptr_r   <= rd_nxt_s;
                                out_data_r <= buf_r[rd_nxt_s];
                                out_last_r <= nxt_is_last_s;
                            end
                        end
                    end
                    default: begin
                        state_r     <= COLLECT;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out_if.out_valid = out_valid_r;
    assign out_if.out_data  = out_data_r;
    assign out_if.out_last  = out_last_r;
    assign busy             = busy_r;
    assign entry_len        = len_r;
    assign overflow         = overflow_r;
    assign dropped          = dropped_r;
    assign timed_out        = timed_out_r;

endmodule

// File: tb/tb_t01_keypad_entry_ctrl.sv
// Self-checking bench for t01_keypad_entry_ctrl (SCAN_DIV=4, MAX_LEN=4, TIMEOUT=20).
// Inputs change on the falling edge; a stream monitor samples 2 time units later
// and checks accepted bytes against a queue of expected beats.
module tb_t01_keypad_entry_ctrl;

    logic       clk = 1'b0;
    logic       nRST;
    logic       scan_en;
    logic       key_valid;
    logic [7:0] key_data;
    logic       clear;
    logic       busy;
    logic [2:0] entry_len;
    logic       overflow;
    logic       dropped;
    logic       timed_out;

    t01_keypad_entry_ctrl_if bus ();

    t01_keypad_entry_ctrl #(.SCAN_DIV(4), .MAX_LEN(4), .TIMEOUT(20)) dut (
        .clk       (clk),
        .nRST      (nRST),
        .scan_en   (scan_en),
        .key_valid (key_valid),
        .key_data  (key_data),
        .clear     (clear),
        .out_if    (bus.master),
        .busy      (busy),
        .entry_len (entry_len),
        .overflow  (overflow),
        .dropped   (dropped),
        .timed_out (timed_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [7:0] key;
        logic [2:0] exp_len;
        logic       exp_ovf;
    } vec_t;

    beat_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    logic  saw_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic press(input logic [7:0] k);
        key_valid = 1'b1;
        key_data  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_data  = 8'h00;
    endtask

    task automatic push(input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        exp_q.push_back(b);
    endtask

    task automatic wait_send_done();
        int n = 0;
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("send_done", {31'd0, busy}, 32'd0);
        chk("len_after_send", {29'd0, entry_len}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);
    endtask

    // Stream monitor: every accepted byte must match the next expected beat.
    always @(negedge clk) begin
        #2;
        if (nRST && !clear && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL stream_extra: got byte %0h expected none", bus.out_data);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                chk("stream_data", {24'd0, bus.out_data}, {24'd0, b.data});
                chk("stream_last", {31'd0, bus.out_last}, {31'd0, b.last});
            end
            if (bus.out_last) saw_last = 1'b1;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[14];
        int   n;
        vecs[0]  = '{8'h31, 3'd1, 1'b0};
        vecs[1]  = '{8'h32, 3'd2, 1'b0};
        vecs[2]  = '{8'h00, 3'd2, 1'b0};
        vecs[3]  = '{8'h2A, 3'd1, 1'b0};
        vecs[4]  = '{8'h33, 3'd2, 1'b0};
        vecs[5]  = '{8'h2A, 3'd1, 1'b0};
        vecs[6]  = '{8'h2A, 3'd0, 1'b0};
        vecs[7]  = '{8'h2A, 3'd0, 1'b0};
        vecs[8]  = '{8'h41, 3'd1, 1'b0};
        vecs[9]  = '{8'h42, 3'd2, 1'b0};
        vecs[10] = '{8'h43, 3'd3, 1'b0};
        vecs[11] = '{8'h44, 3'd4, 1'b0};
        vecs[12] = '{8'h45, 3'd4, 1'b1};
        vecs[13] = '{8'h2A, 3'd3, 1'b0};

        nRST          = 1'b0;
        key_valid     = 1'b0;
        key_data      = 8'h00;
        clear         = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk("reset_outputs", {18'd0, scan_en, bus.out_valid, bus.out_data, bus.out_last,
                              busy, entry_len, overflow, dropped, timed_out}, 32'd0);
        nRST = 1'b1;

        // Scan pacing: pulse on cycles 3, 7, 11, 15 after reset release.
        for (int c = 0; c < 16; c++) begin
            chk("scan_en", {31'd0, scan_en}, {31'd0, ((c % 4) == 3)});
            @(negedge clk);
        end

        // Edit-rule table.
        for (int i = 0; i < 14; i++) begin
            press(vecs[i].key);
            chk("vec_len", {29'd0, entry_len}, {29'd0, vecs[i].exp_len});
            chk("vec_overflow", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
            chk("vec_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end

        // Key coinciding with clear is dropped; entry discarded.
        clear     = 1'b1;
        key_valid = 1'b1;
        key_data  = 8'h31;
        @(negedge clk);
        clear     = 1'b0;
        key_valid = 1'b0;
        key_data  = 8'h00;
        chk("clear_dropped", {31'd0, dropped}, 32'd1);
        chk("clear_len", {29'd0, entry_len}, 32'd0);

        // Entry with backspace, '#' latency of one cycle.
        bus.out_ready = 1'b1;
        press(8'h31); press(8'h32); press(8'h2A); press(8'h33);
        push(8'h31, 1'b0);
        push(8'h33, 1'b1);
        press(8'h23);
        chk("enter_latency_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("enter_first_byte", {24'd0, bus.out_data}, 32'h31);
        chk("enter_busy", {31'd0, busy}, 32'd1);
        wait_send_done();

        // Overflow on the fifth key, then a full-length entry.
        press(8'h31); press(8'h32); press(8'h33); press(8'h34);
        press(8'h35);
        chk("ovf_pulse", {31'd0, overflow}, 32'd1);
        chk("ovf_len", {29'd0, entry_len}, 32'd4);
        @(negedge clk);
        chk("ovf_single", {31'd0, overflow}, 32'd0);
        push(8'h31, 1'b0); push(8'h32, 1'b0); push(8'h33, 1'b0); push(8'h34, 1'b1);
        press(8'h23);
        wait_send_done();

        // Backpressure holds the byte; a key in SEND is dropped.
        bus.out_ready = 1'b0;
        press(8'h31); press(8'h32);
        push(8'h31, 1'b0); push(8'h32, 1'b1);
        press(8'h23);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_data", {24'd0, bus.out_data}, 32'h31);
            chk("bp_last", {31'd0, bus.out_last}, 32'd0);
            @(negedge clk);
        end
        press(8'h39);
        chk("send_dropped", {31'd0, dropped}, 32'd1);
        chk("send_len_kept", {29'd0, entry_len}, 32'd2);
        chk("send_data_kept", {24'd0, bus.out_data}, 32'h31);
        bus.out_ready = 1'b1;
        wait_send_done();

        // Idle timeout after exactly TIMEOUT cycles, then an empty '#'.
        press(8'h37);
        n = 0;
        while (!timed_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 32'd20);
        chk("timeout_pulse", {31'd0, timed_out}, 32'd1);
        chk("timeout_len", {29'd0, entry_len}, 32'd0);
        press(8'h23);
        for (int c = 0; c < 3; c++) begin
            chk("empty_enter_no_valid", {31'd0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end

        // Mid-stream abort by clear.
        bus.out_ready = 1'b0;
        saw_last      = 1'b0;
        press(8'h41); press(8'h42); press(8'h43);
        push(8'h41, 1'b0);
        press(8'h23);
        chk("abort_first", {24'd0, bus.out_data}, 32'h41);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("abort_second", {24'd0, bus.out_data}, 32'h42);
        bus.out_ready = 1'b0;
        clear         = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_len", {29'd0, entry_len}, 32'd0);
        chk("abort_no_last", {31'd0, saw_last}, 32'd0);
        chk("abort_sb_empty", exp_q.size(), 32'd0);

        // Asynchronous reset in the middle of SEND.
        press(8'h35); press(8'h36);
        press(8'h23);
        chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
        #1;
        nRST = 1'b0;
        #1;
        chk("async_reset_outputs", {18'd0, scan_en, bus.out_valid, bus.out_data, bus.out_last,
                                    busy, entry_len, overflow, dropped, timed_out}, 32'd0);
        @(negedge clk);
        nRST = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", {31'd0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/t01_keypad_entry_ctrl.md
Name: t01_keypad_entry_ctrl

Overview:
- Sequences the 4x4 keypad scanner and assembles keypresses into a multi-character entry.
- Paces the scanner's column advance via a periodic scan_en pulse and consumes its one-cycle key_valid/key_data strobes.
- Applies edit rules: '*' = backspace, '#' = enter. Drops entries on timeout or clear.
- Streams a committed entry to the downstream consumer (game/calculator logic) over a valid/ready byte interface with a last flag.

Parameters:
- SCAN_DIV, 1000: clk cycles per scan_en pulse (>=2).
- MAX_LEN, 8: maximum characters per entry (2..16).
- TIMEOUT, 5000000: idle cycles in COLLECT with len>0 before the entry is discarded.

Ports:
- clk  in  1  system clock
- nRST  in  1  reset (see Behaviour)
- scan_en  out  1  one-cycle pulse to the scanner enable (column advance)
- key_valid  in  1  one-cycle keypress strobe from the scanner
- key_data  in  8  ASCII of the pressed key; 0 = unrecognised code
- clear  in  1  synchronous abort of the current entry
- out_valid  out  1  byte available
- out_data  out  8  entry byte, first-typed first
- out_last  out  1  marks the final byte of the entry
- out_ready  in  1  consumer accepts byte
- busy  out  1  high in SEND
- entry_len  out  $clog2(MAX_LEN+1)  current character count
- overflow  out  1  one-cycle pulse: key rejected, buffer full
- dropped  out  1  one-cycle pulse: key arrived in SEND or with clear
- timed_out  out  1  one-cycle pulse: entry discarded by timeout

Behaviour:
- Reset: nRST, asynchronous, active-low; clock clk. All outputs are 0 in reset. State resets to COLLECT; scan counter, len, rd_ptr and idle counter reset to 0.
- Scan pacing:
  - Counter runs 0..SCAN_DIV-1 and wraps.
  - scan_en is high for exactly the cycle the counter equals SCAN_DIV-1, so the period is SCAN_DIV cycles.
  - Runs in all states. Not affected by clear.
- COLLECT state, on key_valid (when clear is low):
  - key_data==0: ignored, no pulse.
  - '*' (0x2A): len<=len-1 if len>0, else no-op.
  - '#' (0x23): if len>0, go to SEND with rd_ptr=0 next cycle; if len==0, ignored.
  - Any other nonzero byte: if len<MAX_LEN, buf[len]<=key_data and len<=len+1; else overflow pulses and the buffer is unchanged.
- Idle timer (COLLECT only):
  - Counts cycles while len>0. Resets to 0 on any key_valid or when len==0.
  - When the count reaches TIMEOUT-1: len<=0, timed_out pulses, timer resets.
  - A key arriving on that same cycle wins: the key is processed and no timeout occurs.
- SEND state:
  - out_valid=1, out_data=buf[rd_ptr], out_last=(rd_ptr==len-1), busy=1.
  - out_data and out_last are stable while out_valid && !out_ready.
  - On out_valid && out_ready: rd_ptr++. If the byte was last, then next cycle len<=0, state COLLECT, and out_valid/busy drop.
  - A key_valid in SEND is discarded and dropped pulses.
- clear (highest priority, any state): next cycle len<=0, rd_ptr<=0, state COLLECT, out_valid=0.
  - A mid-stream abort means out_last is never presented. The consumer discards the partial entry.
  - key_valid coinciding with clear is discarded and dropped pulses.
- entry_len reflects registered len.
- Output latency: outputs are registered or decoded from registered state. Output changes one cycle after the causing input.
- '#' latency: '#' on cycle N gives the first out_valid at N+1.
- Reset mid-SEND: immediate return to reset values; no partial handshake completes.

Decomposition:
- Package t01_keypad_pkg:
  - state enum {COLLECT, SEND} (1-bit logic)
  - constants KEY_ENTER=8'h23, KEY_BKSP=8'h2A, KEY_NONE=8'h00
- One sub-module: t01_scan_divider (param DIV; clk, nRST -> pulse). It holds the scan counter and generates scan_en.

Test Plan:
Bench parameters: SCAN_DIV=4, MAX_LEN=4, TIMEOUT=20.
- Scan pacing: free-run 16 cycles after reset -> scan_en high on cycles 3,7,11,15 only.
- Entry with backspace: keys "1","2","*","3","#", out_ready=1 -> stream 0x31 then 0x33, out_last on 0x33, then busy=0 and entry_len=0.
- Overflow: keys "1","2","3","4","5" -> overflow pulses once on "5", entry_len=4. Then '#' -> bytes 31,32,33,34 with out_last on 34.
- Backpressure: out_ready held low 5 cycles in SEND -> out_data stays 0x31, rd_ptr frozen. A key in SEND pulses dropped and does not alter the stream.
- Timeout: key "7", then no keys for 20 cycles -> timed_out pulses, entry_len=0. An empty '#' afterwards -> no out_valid.
- Mid-stream abort: clear asserted after the first byte of "ABC" is accepted -> out_valid=0 next cycle, state COLLECT, no out_last seen. nRST pulsed mid-SEND -> all outputs 0 immediately.
